fp_mul_pipe: RTL and testbench

Parametrised, fully pipelined IEEE-754 floating-point multiplier. It is the successor to the single-precision FSM multiplier. It adds configurable exponent/mantissa widths, a valid/ready handshake with backpressure, one result per cycle throughput, round-to-nearest-even, and exception flags. It sits in the FP execution unit between the operand-read stage and the writeback/flag-accumulation logic.

---
 rtl/fp_mul_pipe_if.sv | 32 +++
 rtl/fp_mul_pipe.sv | 113 +++++++++++
 tb/tb_fp_mul_pipe.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if: operand/result handshake bundle for the pipelined FP multiplier
//   in_valid/in_ready/A/B          operand channel (producer -> multiplier)
//   out_valid/out_ready/Result     result channel (multiplier -> consumer)
//   flag_invalid/overflow/underflow/inexact  per-result exception flags
//   master: operand producer / result consumer side; slave: the multiplier
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;
    logic         flag_invalid;
    logic         flag_overflow;
    logic         flag_underflow;
    logic         flag_inexact;
    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Result,
        input  flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );
    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Result,
        output flag_invalid, flag_overflow, flag_underflow, flag_inexact
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage IEEE-754 multiplier, RNE rounding, FTZ in/out, valid/ready backpressure
//   clk    rising-edge clock
//   reset  synchronous active-high reset, drops all in-flight operations
//   bus    fp_mul_pipe_if.slave: operands A/B in, Result and flags out
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic        clk,
    input logic        reset,
    fp_mul_pipe_if.slave bus
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int P_W = 2 * MAN_W + 2;
    localparam int E_W = EXP_W + 2;
    localparam logic [E_W-1:0] BIAS  = E_W'(2 ** (EXP_W - 1) - 1);
    localparam logic [E_W-1:0] E_MAX = E_W'(2 ** EXP_W - 1);
    localparam logic [W-1:0]   QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic             en;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inf_zero;
    logic             v1_d, v1_q, s1_d, s1_q, sp1_d, sp1_q, nv1_d, nv1_q;
    logic [W-1:0]     sr1_d, sr1_q;
    logic [EXP_W-1:0] ea1_d, ea1_q, eb1_d, eb1_q;
    logic [MAN_W-1:0] fa1_d, fa1_q, fb1_d, fb1_q;
    logic             v2_d, v2_q, s2_d, s2_q, sp2_d, sp2_q, nv2_d, nv2_q;
    logic [W-1:0]     sr2_d, sr2_q;
    logic [P_W-1:0]   p2_d, p2_q;
    logic [E_W-1:0]   e2_d, e2_q;
    logic             hi, g, st, uf, of, nm;
    logic [MAN_W-1:0] sig;
    logic [MAN_W:0]   rnd;
    logic [E_W-1:0]   e_n, e_r;
    logic             v3_d, v3_q, nv_d, nv_q, of_d, of_q, uf_d, uf_q, nx_d, nx_q;
    logic [W-1:0]     res_d, res_q;

    always_comb begin
        en       = ~v3_q | bus.out_ready;
        {ea, fa} = bus.A[W-2:0];
        {eb, fb} = bus.B[W-2:0];
        sgn      = bus.A[W-1] ^ bus.B[W-1];
        a_nan    = &ea & |fa;
        b_nan    = &eb & |fb;
        a_inf    = &ea & ~|fa;
        b_inf    = &eb & ~|fb;
        // exp == 0 covers both true zeros and flushed subnormals
        a_zero   = ~|ea;
        b_zero   = ~|eb;
        inf_zero = (a_inf & b_zero) | (b_inf & a_zero);
        v1_d     = bus.in_valid;
        s1_d     = sgn;
        sp1_d    = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        sr1_d    = (a_nan | b_nan | inf_zero) ? QNAN :
                   (a_inf | b_inf) ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sgn, {(W-1){1'b0}}};
        nv1_d    = (a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1]) | inf_zero;
        ea1_d    = ea;
        eb1_d    = eb;
        fa1_d    = fa;
        fb1_d    = fb;
        v2_d     = v1_q;
        s2_d     = s1_q;
        sp2_d    = sp1_q;
        sr2_d    = sr1_q;
        nv2_d    = nv1_q;
        p2_d     = P_W'({1'b1, fa1_q}) * P_W'({1'b1, fb1_q});
        e2_d     = {2'b00, ea1_q} + {2'b00, eb1_q} - BIAS;
        // product is in [1,4): a set MSB means one extra exponent step
        hi       = p2_q[P_W-1];
        sig      = hi ? p2_q[P_W-2 -: MAN_W] : p2_q[P_W-3 -: MAN_W];
        g        = hi ? p2_q[P_W-2-MAN_W] : p2_q[P_W-3-MAN_W];
        st       = hi ? |p2_q[P_W-3-MAN_W:0] : |p2_q[P_W-4-MAN_W:0];
        e_n      = e2_q + {{(E_W-1){1'b0}}, hi};
        rnd      = {1'b0, sig} + {{MAN_W{1'b0}}, g & (st | sig[0])};
        // a rounding carry leaves the fraction all-zero, so only the exponent moves
        e_r      = e_n + {{(E_W-1){1'b0}}, rnd[MAN_W]};
        uf       = e_n[E_W-1] | ~|e_n;
        of       = ~uf & (e_r >= E_MAX);
        nm       = v2_q & ~sp2_q;
        v3_d     = v2_q;
        res_d    = ~v2_q ? '0 : sp2_q ? sr2_q : uf ? {s2_q, {(W-1){1'b0}}} :
                   of ? {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {s2_q, e_r[EXP_W-1:0], rnd[MAN_W-1:0]};
        nv_d     = v2_q & sp2_q & nv2_q;
        of_d     = nm & of;
        uf_d     = nm & uf;
        nx_d     = nm & (uf | of | g | st);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0; s1_q <= 1'b0; sp1_q <= 1'b0; nv1_q <= 1'b0; sr1_q <= '0;
            ea1_q <= '0;   eb1_q <= '0;  fa1_q <= '0;   fb1_q <= '0;
            v2_q  <= 1'b0; s2_q <= 1'b0; sp2_q <= 1'b0; nv2_q <= 1'b0; sr2_q <= '0;
            p2_q  <= '0;   e2_q <= '0;
            v3_q  <= 1'b0; res_q <= '0;  nv_q <= 1'b0;  of_q <= 1'b0;  uf_q <= 1'b0; nx_q <= 1'b0;
        end else if (en) begin
            v1_q  <= v1_d;  s1_q <= s1_d;  sp1_q <= sp1_d; nv1_q <= nv1_d; sr1_q <= sr1_d;
            ea1_q <= ea1_d; eb1_q <= eb1_d; fa1_q <= fa1_d; fb1_q <= fb1_d;
            v2_q  <= v2_d;  s2_q <= s2_d;  sp2_q <= sp2_d; nv2_q <= nv2_d; sr2_q <= sr2_d;
            p2_q  <= p2_d;  e2_q <= e2_d;
            v3_q  <= v3_d;  res_q <= res_d; nv_q <= nv_d;  of_q <= of_d;  uf_q <= uf_d; nx_q <= nx_d;
        end
    end

    assign bus.in_ready       = en;
    assign bus.out_valid      = v3_q;
    assign bus.Result         = res_q;
    assign bus.flag_invalid   = nv_q;
    assign bus.flag_overflow  = of_q;
    assign bus.flag_underflow = uf_q;
    assign bus.flag_inexact   = nx_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: vector table, corner sequences and randomized scoreboard for fp_mul_pipe
module tb_fp_mul_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_mul_pipe_if bus ();
    fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) hbus ();

    fp_mul_pipe u_dut (.clk(clk), .reset(reset), .bus(bus.slave));
    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_half (.clk(clk), .reset(reset), .bus(hbus.slave));

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;   // {invalid, overflow, underflow, inexact}
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [35:0] outv();
        return {bus.Result, bus.flag_invalid, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact};
    endfunction

    // Reference: exact integer product, rounded by comparing the discarded remainder to one half-ulp
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s, an, bn, ai, bi, az, bz, nv, up;
        int ea, eb, e, shift;
        logic [22:0] fa, fb;
        longint unsigned p, q, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        az = (ea == 0);
        bz = (eb == 0);
        if (an || bn || (ai && bz) || (bi && az)) begin
            nv = (an && !fa[22]) || (bn && !fb[22]) || (ai && bz) || (bi && az);
            return {32'h7FC00000, nv, 3'b000};
        end
        if (ai || bi) return {s, 8'hFF, 23'h0, 4'b0000};
        if (az || bz) return {s, 31'h0, 4'b0000};
        p = 64'({1'b1, fa}) * 64'({1'b1, fb});
        e = ea + eb - 127;
        shift = p[47] ? 24 : 23;
        e = e + shift - 23;
        q = p >> shift;
        rem = p - (q << shift);
        half = 64'd1 << (shift - 1);
        if (e <= 0) return {s, 31'h0, 4'b0011};
        up = (rem > half) || ((rem == half) && q[0]);
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0, 4'b0101};
        return {s, 8'(e), q[22:0], 3'b000, rem != 0};
    endfunction

    function automatic logic [31:0] gen_op();
        int r;
        logic [7:0] e;
        logic [22:0] f;
        r = $urandom_range(0, 9);
        f = 23'($urandom);
        e = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : (r <= 3) ? 8'($urandom_range(1, 20)) :
            (r <= 5) ? 8'($urandom_range(230, 254)) : 8'($urandom_range(100, 154));
        if (r == 1 && $urandom_range(0, 1) == 0) f = 23'h0;
        return {1'($urandom), e, f};
    endfunction

    // Single op with out_ready high; lat counts edges from the accepting edge until out_valid is seen
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, output logic [35:0] got, output int lat);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = outv();
    endtask

    vec_t vecs[$];
    logic [35:0] exp_q[$];
    logic [35:0] got, held;
    int lat, sent, recv, cyc, stray;
    logic pending, held_v;
    logic [31:0] ops_a[8], ops_b[8];

    initial begin
        vecs.push_back('{"basic",  32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000});
        vecs.push_back('{"negmul", 32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000});
        vecs.push_back('{"tie",    32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001});
        vecs.push_back('{"sq",     32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001});
        vecs.push_back('{"exact",  32'h40000000, 32'h40000000, 32'h40800000, 4'b0000});
        vecs.push_back('{"of",     32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101});
        vecs.push_back('{"ofneg",  32'hFF000000, 32'h40000000, 32'hFF800000, 4'b0101});
        vecs.push_back('{"uf",     32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011});
        vecs.push_back('{"subftz", 32'h00000001, 32'h40000000, 32'h00000000, 4'b0000});
        vecs.push_back('{"infz",   32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000});
        vecs.push_back('{"qnan",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000});
        vecs.push_back('{"snan",   32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000});
        vecs.push_back('{"ninf",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000});
        vecs.push_back('{"nzero",  32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000});

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.A = '0; bus.B = '0;
        hbus.in_valid = 1'b0; hbus.out_ready = 1'b1; hbus.A = '0; hbus.B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result_flags", 64'(outv()), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_one(vecs[i].a, vecs[i].b, got, lat);
            check({"vec_", vecs[i].name}, 64'(got), 64'({vecs[i].res, vecs[i].fl}));
            check({"lat_", vecs[i].name}, 64'(lat), 64'd3);
        end

        @(negedge clk);
        hbus.A = 16'h4200; hbus.B = 16'h4100; hbus.in_valid = 1'b1;
        @(negedge clk);
        hbus.in_valid = 1'b0;
        lat = 1;
        while (!hbus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("half_basic", 64'({hbus.Result, hbus.flag_invalid, hbus.flag_overflow,
                                 hbus.flag_underflow, hbus.flag_inexact}), 64'({16'h4780, 4'b0000}));
        check("half_lat", 64'(lat), 64'd3);

        // Backpressure: 8 back-to-back ops with a 5-cycle consumer stall
        for (int i = 0; i < 8; i++) begin
            ops_a[i] = vecs[i].a;
            ops_b[i] = vecs[i].b;
        end
        exp_q.delete();
        sent = 0; recv = 0; held_v = 1'b0; held = '0;
        for (int t = 0; t < 60 && recv < 8; t++) begin
            @(negedge clk);
            bus.in_valid = (sent < 8);
            bus.A = ops_a[sent % 8];
            bus.B = ops_b[sent % 8];
            bus.out_ready = !(t >= 4 && t <= 8);
            #1;
            if (held_v) check("bp_hold", 64'(outv()), 64'(held));
            held_v = bus.out_valid && !bus.out_ready;
            held = outv();
            if (bus.out_valid && !bus.out_ready) check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("bp_extra", 64'd1, 64'd0);
                else check("bp_result", 64'(outv()), 64'(exp_q.pop_front()));
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_mul(bus.A, bus.B));
                sent++;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        check("bp_count", 64'(recv), 64'd8);
        check("bp_no_dup", 64'(stray + exp_q.size()), 64'd0);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b1;
            bus.A = vecs[i].a;
            bus.B = vecs[i].b;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result_flags", 64'(outv()), 64'd0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        check("rst_no_ghost", 64'(stray), 64'd0);
        run_one(32'h40400000, 32'h40200000, got, lat);
        check("rst_new_op", 64'(got), 64'({32'h40F00000, 4'b0000}));
        check("rst_new_lat", 64'(lat), 64'd3);

        // Randomized traffic against the reference model
        @(negedge clk);
        exp_q.delete();
        sent = 0; recv = 0; cyc = 0; pending = 1'b0; held_v = 1'b0;
        while (recv < 10000 && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            if (!pending && sent < 10000 && $urandom_range(0, 3) != 0) begin
                bus.A = gen_op();
                bus.B = gen_op();
                pending = 1'b1;
            end
            bus.in_valid = pending;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (held_v) check("rand_hold", 64'(outv()), 64'(held));
            held_v = bus.out_valid && !bus.out_ready;
            held = outv();
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("rand_extra", 64'd1, 64'd0);
                else check("rand_result", 64'(outv()), 64'(exp_q.pop_front()));
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_mul(bus.A, bus.B));
                sent++;
                pending = 1'b0;
            end
        end
        check("rand_count", 64'(recv), 64'd10000);
        bus.in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
